jts16_snd_latch: RTL and testbench



---
 rtl/jts16_snd_pkg.sv | 25 ++
 rtl/jts16_snd_strobe.sv | 74 +++++++
 rtl/jts16_snd_latch.sv | 145 ++++++++++++++
 tb/tb_jts16_snd_latch.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/jts16_snd_pkg.sv
`default_nettype none
// ============================================================================
//  Module  : jts16_snd_pkg
//  Purpose : Shared types and constants for the System 16A sound command
//            latch (main 68000 -> sound Z80 channel).
//  Contents: snd_state_t   latch state encoding (IDLE/PEND/SERVED)
//            FIFO_DEPTH    entries used when JTS16_SNDLATCH_FIFO_EN is defined
//            c_dout_rst    value shown on dout while nothing is held
//            c_snd_ack_rst snd_ack value out of reset (latch empty)
//  Revision: 1.0  initial release
// ============================================================================
package jts16_snd_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      PEND   = 2'd1,
      SERVED = 2'd2
   } snd_state_t;

   localparam int         FIFO_DEPTH    = 4;
   localparam logic [7:0] c_dout_rst    = 8'hFF;
   localparam logic       c_snd_ack_rst = 1'b1;

endpackage
`default_nettype wire

// File: rtl/jts16_snd_strobe.sv
`default_nettype none
// ============================================================================
//  Module  : jts16_snd_strobe
//  Purpose : Turns the asynchronous, active-low snd_irqn command strobe into a
//            single clk-wide capture pulse. The strobe is synchronised, must be
//            seen low for FILT consecutive samples, and the block re-arms only
//            after a synchronised high sample, so a long low gives one pulse.
//  Ports   : clk       system clock
//            rst       synchronous reset, active high
//            snd_irqn  raw command strobe (falling edge = new command)
//            cap       one-cycle capture pulse
//  Params  : SYNC  synchroniser depth (1..3)
//            FILT  consecutive low samples required to accept a strobe
//  Revision: 1.0  initial release
// ============================================================================
module jts16_snd_strobe #(
   parameter int SYNC = 2,
   parameter int FILT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic snd_irqn,
   output logic cap
);

   localparam int            CW         = $clog2(FILT + 1);
   localparam logic [CW-1:0] c_filt     = CW'(FILT);
   localparam logic [CW-1:0] c_filt_m1  = CW'(FILT - 1);

   logic [SYNC-1:0] r_sync;
   logic            w_synced;
   logic [CW-1:0]   r_cnt;
   logic            r_armed;
   logic            r_cap;

   // Chain is preset high so reset never looks like a strobe.
   generate
      if (SYNC == 1) begin : g_sync_one
         always_ff @(posedge clk) begin
            if (rst) r_sync <= '1;
            else     r_sync <= snd_irqn;
         end
      end else begin : g_sync_chain
         always_ff @(posedge clk) begin
            if (rst) r_sync <= '1;
            else     r_sync <= {r_sync[SYNC-2:0], snd_irqn};
         end
      end
   endgenerate

   assign w_synced = r_sync[SYNC-1];

   // r_cnt holds the number of low samples seen before the current one, so the
   // pulse is raised on the edge that samples the FILT-th consecutive low.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt   <= '0;
         r_armed <= 1'b1;
         r_cap   <= 1'b0;
      end else if (w_synced) begin
         r_cnt   <= '0;
         r_armed <= 1'b1;
         r_cap   <= 1'b0;
      end else begin
         if (r_cnt != c_filt) r_cnt <= r_cnt + 1'b1;
         r_cap <= r_armed && (r_cnt == c_filt_m1);
         if (r_armed && (r_cnt == c_filt_m1)) r_armed <= 1'b0;
      end
   end

   assign cap = r_cap;

endmodule
`default_nettype wire

// File: rtl/jts16_snd_latch.sv
`default_nettype none
// ============================================================================
//  Module  : jts16_snd_latch
//  Purpose : Sound-CPU end of the System 16A main-to-sound command channel.
//            Captures the command byte on a filtered snd_irqn strobe, raises
//            the Z80 INT and reports the latch status back to the 68000.
//  Ports   : clk, rst   clock and synchronous active-high reset
//            snd_latch  command byte from PPI port A
//            snd_irqn   command strobe from PPI port C bit 7
//            snd_ack    to PPI port C bit 6 (1 = empty/read, 0 = pending)
//            latch_rd   one-cycle Z80 read of the latch port
//            int_ack    one-cycle Z80 interrupt acknowledge
//            dout       latch data to the Z80 bus
//            int_n      Z80 INT, active low
//            ovr_cnt    saturating count of overwritten/dropped commands
//  Options : JTS16_SNDLATCH_FIFO_EN  replaces the single latch with a
//            4-entry FIFO.
//  Revision: 1.0  initial release
// ============================================================================
module jts16_snd_latch #(
   parameter int SYNC = 2,
   parameter int FILT = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] snd_latch,
   input  logic       snd_irqn,
   output logic       snd_ack,
   input  logic       latch_rd,
   input  logic       int_ack,
   output logic [7:0] dout,
   output logic       int_n,
   output logic [7:0] ovr_cnt
);
   import jts16_snd_pkg::*;

   logic w_cap;

   jts16_snd_strobe #(
      .SYNC (SYNC),
      .FILT (FILT)
   ) u_strobe (
      .clk      (clk),
      .rst      (rst),
      .snd_irqn (snd_irqn),
      .cap      (w_cap)
   );

`ifdef JTS16_SNDLATCH_FIFO_EN
   logic [7:0] r_mem [FIFO_DEPTH];
   logic [1:0] r_wr;
   logic [1:0] r_rd;
   logic [2:0] r_fill;
   logic       r_served;   // head entry has been interrupt-acknowledged
   logic [7:0] r_ovr;
   logic       w_empty;
   logic       w_full;
   logic       w_pop;
   logic       w_push;
   logic       w_drop;

   assign w_empty = (r_fill == 3'd0);
   assign w_full  = (r_fill == 3'(FIFO_DEPTH));
   assign w_pop   = latch_rd && !w_empty;
   // The pop frees a slot first, so a push into a full FIFO with a
   // simultaneous pop is accepted.
   assign w_push  = w_cap && (!w_full || w_pop);
   assign w_drop  = w_cap && !w_push;

   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr] <= snd_latch;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_wr     <= 2'd0;
         r_rd     <= 2'd0;
         r_fill   <= 3'd0;
         r_served <= 1'b0;
         r_ovr    <= 8'd0;
      end else begin
         if (w_push) r_wr <= r_wr + 2'd1;
         if (w_pop)  r_rd <= r_rd + 2'd1;
         case ({w_push, w_pop})
            2'b10:   r_fill <= r_fill + 3'd1;
            2'b01:   r_fill <= r_fill - 3'd1;
            default: r_fill <= r_fill;
         endcase
         // A new head always starts unacknowledged.
         if (w_pop)                    r_served <= 1'b0;
         else if (int_ack && !w_empty) r_served <= 1'b1;
         if (w_drop && (r_ovr != 8'hFF)) r_ovr <= r_ovr + 8'd1;
      end
   end

   assign dout    = w_empty ? c_dout_rst : r_mem[r_rd];
   assign int_n   = !(!w_empty && !r_served);
   assign snd_ack = w_empty;
   assign ovr_cnt = r_ovr;
`else
   snd_state_t r_state;
   snd_state_t w_next;
   logic       r_int_n;
   logic       r_ack;
   logic [7:0] r_dout;
   logic [7:0] r_ovr;

   // Capture has priority over both read and interrupt acknowledge.
   always_comb begin
      w_next = r_state;
      if (w_cap)
         w_next = PEND;
      else if (latch_rd && (r_state != IDLE))
         w_next = IDLE;
      else if (int_ack && (r_state == PEND))
         w_next = SERVED;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_int_n <= 1'b1;
         r_ack   <= c_snd_ack_rst;
         r_dout  <= c_dout_rst;
         r_ovr   <= 8'd0;
      end else begin
         r_state <= w_next;
         r_int_n <= (w_next != PEND);
         r_ack   <= (w_next == IDLE);
         if (w_cap) r_dout <= snd_latch;
         // A read in the capture cycle consumes the old byte, so the
         // replacement is not an overrun.
         if (w_cap && (r_state != IDLE) && !latch_rd && (r_ovr != 8'hFF))
            r_ovr <= r_ovr + 8'd1;
      end
   end

   assign dout    = r_dout;
   assign int_n   = r_int_n;
   assign snd_ack = r_ack;
   assign ovr_cnt = r_ovr;
`endif

endmodule
`default_nettype wire

// File: tb/tb_jts16_snd_latch.sv
`default_nettype none
// ============================================================================
//  Module  : tb_jts16_snd_latch
//  Purpose : Self-checking bench for jts16_snd_latch. Stimulus queues the
//            expected responses; monitors compare them when the DUT presents
//            a read, an interrupt, or reaches a scheduled cycle.
//  Revision: 1.0  initial release
// ============================================================================
module tb_jts16_snd_latch;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [7:0] snd_latch = 8'h00;
   logic       snd_irqn = 1'b1;
   logic       latch_rd = 1'b0;
   logic       int_ack = 1'b0;
   logic       snd_ack;
   logic [7:0] dout;
   logic       int_n;
   logic [7:0] ovr_cnt;

   always #5 clk = ~clk;

   jts16_snd_latch #(.SYNC(2), .FILT(2)) dut (
      .clk       (clk),
      .rst       (rst),
      .snd_latch (snd_latch),
      .snd_irqn  (snd_irqn),
      .snd_ack   (snd_ack),
      .latch_rd  (latch_rd),
      .int_ack   (int_ack),
      .dout      (dout),
      .int_n     (int_n),
      .ovr_cnt   (ovr_cnt)
   );

   typedef struct {
      int         cyc;
      logic       int_n;
      logic       ack;
      logic [7:0] dout;
      logic [7:0] ovr;
      int         tag;
   } chk_t;

   typedef struct {
      int         cyc;
      logic [7:0] dout;
   } cap_t;

   chk_t       chk_q[$];
   cap_t       cap_q[$];
   logic [7:0] rd_q[$];

   int cyc    = 0;
   int n_chk  = 0;
   int n_pass = 0;
   logic prev_int_n = 1'b1;

   function automatic void check(string nm, int tag, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s[%0d]: got %0h, expected %0h", nm, tag, act, exp);
   endfunction

   // Posedge monitor: interrupt assertions and scheduled state checks.
   always begin : mon_pos
      chk_t k;
      cap_t c;
      int   i;
      @(posedge clk);
      cyc++;
      #1;
      if (prev_int_n === 1'b1 && int_n === 1'b0) begin
         if (cap_q.size() == 0) check("spurious_int", cyc, 32'(int_n), 32'd1);
         else begin
            c = cap_q.pop_front();
            check("cap_dout",  cyc, 32'(dout), 32'(c.dout));
            check("cap_cycle", cyc, 32'(cyc),  32'(c.cyc));
         end
      end
      prev_int_n = int_n;
      i = 0;
      while (i < chk_q.size()) begin
         if (chk_q[i].cyc == cyc) begin
            k = chk_q[i];
            chk_q.delete(i);
            check("int_n",   k.tag, 32'(int_n),   32'(k.int_n));
            check("snd_ack", k.tag, 32'(snd_ack), 32'(k.ack));
            check("dout",    k.tag, 32'(dout),    32'(k.dout));
            check("ovr_cnt", k.tag, 32'(ovr_cnt), 32'(k.ovr));
         end else begin
            i++;
         end
      end
   end

   // Read monitor: compares the byte the Z80 sees during each latch_rd.
   always begin : mon_rd
      @(negedge clk);
      #1;
      if (latch_rd === 1'b1) begin
         if (rd_q.size() == 0) check("unexpected_read", cyc, 32'(latch_rd), 32'd0);
         else                  check("read_dout", cyc, 32'(dout), 32'(rd_q.pop_front()));
      end
   end

   task automatic idle(int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic expect_state(int dly, logic i_n, logic ak, logic [7:0] d, logic [7:0] o, int tag);
      chk_q.push_back('{cyc + dly, i_n, ak, d, o, tag});
   endtask

   // Drives a strobe of 'low' clocks; interrupt expected 5 edges after start
   // (2 sync + 2 filter + 1 load). Optionally reads in the capture cycle.
   task automatic strobe(logic [7:0] b, int low, bit exp_cap, bit rd_at_cap);
      int t0;
      int n;
      t0 = cyc;
      snd_latch = b;
      snd_irqn  = 1'b0;
      if (exp_cap) cap_q.push_back('{t0 + 5, b});
      n = (low > 8) ? low : 8;
      for (int i = 1; i <= n; i++) begin
         @(negedge clk);
         if (i == low) snd_irqn = 1'b1;
         latch_rd = rd_at_cap && (i == 4);
      end
      latch_rd = 1'b0;
      snd_irqn = 1'b1;
   endtask

   task automatic pulse_rd(logic [7:0] exp);
      rd_q.push_back(exp);
      latch_rd = 1'b1;
      @(negedge clk);
      latch_rd = 1'b0;
   endtask

   task automatic pulse_ack();
      int_ack = 1'b1;
      @(negedge clk);
      int_ack = 1'b0;
   endtask

   initial begin
      idle(3);
      rst = 1'b0;
      expect_state(1, 1'b1, 1'b1, 8'hFF, 8'd0, 0);
      idle(4);
`ifdef JTS16_SNDLATCH_FIFO_EN
      expect_state(5, 1'b0, 1'b0, 8'h01, 8'd0, 20);
      strobe(8'h01, 2, 1'b1, 1'b0);
      strobe(8'h02, 2, 1'b0, 1'b0);
      strobe(8'h03, 2, 1'b0, 1'b0);
      strobe(8'h04, 2, 1'b0, 1'b0);
      strobe(8'h05, 2, 1'b0, 1'b0);
      expect_state(1, 1'b0, 1'b0, 8'h01, 8'd1, 21);
      idle(2);
      pulse_rd(8'h01); idle(1);
      pulse_rd(8'h02); idle(1);
      pulse_rd(8'h03); idle(1);
      expect_state(1, 1'b1, 1'b1, 8'hFF, 8'd1, 22);
      pulse_rd(8'h04); idle(1);
      pulse_rd(8'hFF); idle(2);
      // Served head, then a pop exposes an unserved entry: INT drops again.
      expect_state(5, 1'b0, 1'b0, 8'hAA, 8'd1, 23);
      strobe(8'hAA, 2, 1'b1, 1'b0);
      expect_state(1, 1'b1, 1'b0, 8'hAA, 8'd1, 24);
      pulse_ack();
      strobe(8'hBB, 2, 1'b0, 1'b0);
      cap_q.push_back('{cyc + 1, 8'hBB});
      pulse_rd(8'hAA);
      idle(2);
      strobe(8'hCC, 2, 1'b0, 1'b0);
      expect_state(0, 1'b0, 1'b0, 8'hBB, 8'd1, 25);
      idle(1);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      expect_state(1, 1'b1, 1'b1, 8'hFF, 8'd0, 26);
      idle(3);
`else
      expect_state(5, 1'b0, 1'b0, 8'h5A, 8'd0, 1);
      strobe(8'h5A, 3, 1'b1, 1'b0);
      expect_state(1, 1'b1, 1'b0, 8'h5A, 8'd0, 2);
      pulse_ack();
      idle(2);
      expect_state(1, 1'b1, 1'b1, 8'h5A, 8'd0, 3);
      pulse_rd(8'h5A);
      idle(2);
      // One-clock glitch is filtered out.
      expect_state(8, 1'b1, 1'b1, 8'h5A, 8'd0, 4);
      strobe(8'h77, 1, 1'b0, 1'b0);
      // Fifty-clock low yields exactly one capture.
      expect_state(52, 1'b0, 1'b0, 8'h66, 8'd0, 5);
      strobe(8'h66, 50, 1'b1, 1'b0);
      idle(4);
      pulse_rd(8'h66);
      idle(2);
      strobe(8'h11, 2, 1'b1, 1'b0);
      expect_state(5, 1'b0, 1'b0, 8'h22, 8'd1, 6);
      strobe(8'h22, 2, 1'b0, 1'b0);
      // Read coincident with capture: old byte read, no overrun.
      rd_q.push_back(8'h22);
      expect_state(5, 1'b0, 1'b0, 8'h33, 8'd1, 7);
      strobe(8'h33, 2, 1'b0, 1'b1);
      expect_state(1, 1'b1, 1'b1, 8'h33, 8'd1, 8);
      pulse_rd(8'h33);
      expect_state(1, 1'b1, 1'b1, 8'h33, 8'd1, 9);
      pulse_ack();
      idle(2);
      for (int i = 0; i < 300; i++) strobe(8'(i), 2, (i == 0), 1'b0);
      expect_state(1, 1'b0, 1'b0, 8'h2B, 8'hFF, 10);
      idle(2);
      expect_state(1, 1'b1, 1'b1, 8'h2B, 8'hFF, 11);
      pulse_rd(8'h2B);
      idle(2);
      // Reset while a command is pending discards it.
      expect_state(5, 1'b0, 1'b0, 8'h44, 8'hFF, 12);
      strobe(8'h44, 2, 1'b1, 1'b0);
      rst = 1'b1;
      idle(2);
      rst = 1'b0;
      expect_state(1, 1'b1, 1'b1, 8'hFF, 8'd0, 13);
      idle(3);
`endif
      idle(10);
      check("cap_q_drained", 0, 32'(cap_q.size()), 32'd0);
      check("rd_q_drained",  0, 32'(rd_q.size()),  32'd0);
      check("chk_q_drained", 0, 32'(chk_q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation exceeded time budget");
      $fatal(1);
   end

endmodule
`default_nettype wire
